// File: rtl/divider_sequencer.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with its own FSM.
// Optional: define DIVIDER_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module divider_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startE,
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic [XLEN-1:0] result_divide,
    output logic            done,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic            sgn_q, a_neg_q, b_neg_q, rem_op_q;

    // Request-side decode, evaluated combinationally in IDLE
    logic            is_signed, a_neg, b_neg, div_zero, ovf, early, special, accept;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign is_signed = ~div_opcode[0];
    assign a_neg     = is_signed & operand1[XLEN-1];
    assign b_neg     = is_signed & operand2[XLEN-1];
    assign mag_a     = a_neg ? -operand1 : operand1;
    assign mag_b     = b_neg ? -operand2 : operand2;
    assign div_zero  = (operand2 == '0);
    assign ovf       = is_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (&operand2);
`ifdef DIVIDER_EARLY_OUT_EN
    assign early     = ~div_zero && (mag_a < mag_b);
`else
    assign early     = 1'b0;
`endif
    assign special   = div_zero | ovf | early;
    assign accept    = (state == IDLE) && startE && !flush;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = div_opcode[1] ? operand1 : '1;
        else if (ovf)
            special_res = div_opcode[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else
            special_res = div_opcode[1] ? operand1 : '0;
    end

    // One restoring step: shift {rem, quo} left, try subtracting the divisor
    logic [XLEN:0]   trial;
    logic            step_ok;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_fix, r_fix;

    assign trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
    assign step_ok = ~trial[XLEN];
    assign rem_nxt = step_ok ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign quo_nxt = {quo_q[XLEN-2:0], step_ok};
    assign q_fix   = (sgn_q && (a_neg_q ^ b_neg_q)) ? -quo_nxt : quo_nxt;
    assign r_fix   = (sgn_q && a_neg_q) ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                busy      = 1'b1;
                state_nxt = special ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (flush)         state_nxt = IDLE;
                else if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = ~flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath; result_divide only moves on the edge that enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            sgn_q         <= 1'b0;
            a_neg_q       <= 1'b0;
            b_neg_q       <= 1'b0;
            rem_op_q      <= 1'b0;
            result_divide <= '0;
        end else if (accept) begin
            sgn_q    <= is_signed;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            rem_op_q <= div_opcode[1];
            dvsr_q   <= mag_b;
            rem_q    <= '0;
            quo_q    <= mag_a;
            cnt      <= CW'(XLEN-1);
            if (special) result_divide <= special_res;
        end else if (state == RUN && !flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt - CW'(1);
            if (cnt == '0) result_divide <= rem_op_q ? r_fix : q_fix;
        end
    end
endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: driver pushes expected result and busy length, monitor pops on done.
module tb_divider_sequencer;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            startE = 1'b0;
    logic [1:0]      div_opcode = '0;
    logic [XLEN-1:0] operand1 = '0, operand2 = '0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] result_divide;
    logic            done, busy;

    divider_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .startE(startE), .div_opcode(div_opcode),
        .operand1(operand1), .operand2(operand2), .flush(flush),
        .result_divide(result_divide), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [XLEN-1:0] res; int bsy; } exp_t;
    exp_t            sb[$];
    int              n_vec = 0, n_err = 0;
    logic [XLEN-1:0] held = '0;
    int              busy_run = 0, busy_last = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain RISC-V division semantics
    function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        longint sa, sb;
        if (b == 0) return op[1] ? a : '1;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? XLEN'(sa % sb) : XLEN'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int exp_busy(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        longint ma, mb;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = op[0] ? longint'(a) : longint'($signed(a));
        mb = op[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIVIDER_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Monitor: busy run length includes the request cycle; done follows it directly
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_run++;
        else begin
            if (busy_run != 0) busy_last = busy_run;
            busy_run = 0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: got result %h with empty scoreboard", result_divide);
            end else begin
                e = sb.pop_front();
                chk("result", result_divide, e.res);
                chk("busy_cycles", XLEN'(busy_last), XLEN'(e.bsy));
                held = e.res;
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        bit   seen = 0;
        e.res = model(op, a, b);
        e.bsy = exp_busy(op, a, b);
        sb.push_back(e);
        @(posedge clk); #1;
        startE = 1'b1; div_opcode = op; operand1 = a; operand2 = b;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL timeout: no done for op %0d %h / %h", op, a, b);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        startE = 1'b0;
    endtask

    task automatic start_only(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(posedge clk); #1;
        startE = 1'b1; div_opcode = op; operand1 = a; operand2 = b;
    endtask

    function automatic logic [XLEN-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return XLEN'($urandom_range(0, 40));
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0;
            4:       return -XLEN'($urandom_range(1, 40));
            default: return XLEN'($urandom);
        endcase
    endfunction

    initial begin
        #1;
        chk("reset_result", result_divide, '0);
        chk("reset_done", XLEN'(done), '0);
        chk("reset_busy", XLEN'(busy), '0);
        #20 rst = 1'b0;

        do_op(2'b01, 100, 7);
        do_op(2'b11, 100, 7);
        do_op(2'b00, 32'hFFFF_FFF9, 2);
        do_op(2'b10, 32'hFFFF_FFF9, 2);
        do_op(2'b00, 5, 0);
        do_op(2'b11, 5, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b01, 3, 10);
        do_op(2'b11, 3, 10);
        do_op(2'b00, 32'hFFFF_FFFD, 10);

        // Flush mid-run: no done, busy drops, result keeps old value
        start_only(2'b01, 1000, 3);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; startE = 1'b0;
        @(negedge clk);
        chk("flush_done", XLEN'(done), '0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", XLEN'(busy), '0);
        chk("flush_result", result_divide, held);
        repeat (3) @(negedge clk);
        chk("flush_result_hold", result_divide, held);

        // Asynchronous reset mid-run
        start_only(2'b01, 1000, 3);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1; startE = 1'b0;
        #1;
        chk("arst_result", result_divide, '0);
        chk("arst_done", XLEN'(done), '0);
        chk("arst_busy", XLEN'(busy), '0);
        held = '0;
        @(posedge clk); #1 rst = 1'b0;
        do_op(2'b01, 1000, 3);

        for (int k = 0; k < 60; k++)
            do_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
